ysyx_23060201_idu: RTL and testbench
====================================

Name: ysyx_23060201_idu

Overview:
Instruction decode stage that sits directly downstream of the fetch unit. Accepts a (pc, inst) pair over a valid/ready handshake and splits the instruction into register indices, a sign-extended immediate, an instruction-class code and an illegal flag. Results are presented through a registered output slot, with a one-entry skid buffer so that `in_ready` is a pure register output. A `flush` input discards all held instructions when execute redirects the PC.

Parameters:
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, instruction and immediate width.
- REG_ADDR_WIDTH, 5, register index width. 5 = RV32I; 4 = RV32E.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  fetch presents a valid pc/inst.
- in_ready  out  1  IDU can accept; registered.
- in_pc  in  ADDR_WIDTH  PC of the incoming instruction.
- in_inst  in  DATA_WIDTH  raw instruction word.
- flush  in  1  discard all held entries.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  execute accepts.
- out_pc  out  ADDR_WIDTH  PC of the decoded instruction.
- out_inst  out  DATA_WIDTH  raw instruction word.
- out_rs1  out  REG_ADDR_WIDTH  inst[15+:REG_ADDR_WIDTH].
- out_rs2  out  REG_ADDR_WIDTH  inst[20+:REG_ADDR_WIDTH].
- out_rd  out  REG_ADDR_WIDTH  inst[7+:REG_ADDR_WIDTH].
- out_imm  out  DATA_WIDTH  sign-extended immediate.
- out_type  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SYS, 7=ILLEGAL.
- out_illegal  out  1  set exactly when out_type==7.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - out_valid=0, skid buffer empty, in_ready=1.
  - All data outputs are 0.
- Storage: output slot (OUT) plus skid entry (SKID). The states are EMPTY, ONE (OUT full), TWO (OUT and SKID full).
- Handshakes:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Data outputs are held stable while out_valid=1 and out_ready=0.
- Transitions:
  - EMPTY, input transfer: decode into OUT → ONE. Latency is 1 cycle from accept to out_valid.
  - ONE, input transfer only: decoded result goes to SKID → TWO, and in_ready drops to 0 next cycle.
  - ONE, output transfer only → EMPTY.
  - ONE, both transfers in the same cycle: new result goes to OUT, state stays ONE.
  - TWO, output transfer: SKID moves to OUT → ONE, and in_ready=1 next cycle.
  - TWO: no input is accepted because in_ready=0.
- in_ready is 1 in EMPTY and ONE, 0 in TWO. It is derived from registered state only, with no combinational path from out_ready.
- flush:
  - At the next edge, OUT and SKID are invalidated → EMPTY.
  - Any input transfer in the flush cycle is dropped.
  - flush overrides all other transitions.
  - rst overrides flush.
- Decode: combinational on the entering inst, registered into OUT/SKID.
  - opcode 0110011 → R, imm=0.
  - opcodes 0010011, 0000011, 1100111 → I, imm=sext(inst[31:20]).
  - opcode 0100011 → S, imm=sext({inst[31:25],inst[11:7]}).
  - opcode 1100011 → B, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - opcodes 0110111, 0010111 → U, imm={inst[31:12],12'b0}.
  - opcode 1101111 → J, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - opcode 1110011 → SYS, imm=sext(inst[31:20]).
  - Any other opcode → ILLEGAL, imm=0.
  - RV32E (REG_ADDR_WIDTH=4): if inst[19], inst[24] or inst[11] is 1 for a field the type uses, the type becomes ILLEGAL.
- Register fields are always extracted regardless of type; consumers ignore fields their type does not use.

Optional Feature:
- Macro: YSYX_23060201_IDU_PERF_EN.
- When defined, adds three 32-bit output counters, reset to 0 by rst and not affected by flush; each wraps at 2^32:
  - perf_decoded increments on each output transfer.
  - perf_stall increments on each cycle with out_valid & ~out_ready.
  - perf_flushed increments on each flush cycle in which state≠EMPTY.
- When undefined, these ports and their logic do not exist.

Test Plan:
1. After reset, drive in_inst=0x00500093, in_pc=0x80000000, with out_ready=1. Next cycle: out_valid=1, type=I, rd=1, rs1=0, imm=5, out_pc=0x80000000.
2. Decode coverage:
   - 0x0020A423 → type=S, rs1=1, rs2=2, imm=8.
   - 0xFE000EE3 → type=B, imm=0xFFFFFFFC.
   - 0x800002B7 → type=U, rd=5, imm=0x80000000.
   - 0x0000006F → type=J, imm=0.
   - 0x00100073 → type=SYS.
   - 0x00000000 → type=ILLEGAL, illegal=1.
3. Backpressure: hold out_ready=0 and stream 3 instructions. Required: the first two are accepted, in_ready=0 after the second, and the outputs stay stable. Then raise out_ready: instructions drain in order, with no loss or duplication.
4. Simultaneous transfers: in ONE with in_valid=1 and out_ready=1 continuously for 10 cycles. Required: one instruction per cycle, in_ready stays 1.
5. flush in TWO with in_valid=1. Next cycle: out_valid=0, in_ready=1, and the flushed-cycle input never appears on the output.
6. Assert rst mid-stream while in TWO. Next cycle: out_valid=0, in_ready=1, and all data outputs are 0.

Source files
------------

// File: rtl/ysyx_23060201_idu.sv
// ============================================================================
// ysyx_23060201_idu -- instruction decode unit
//
// Purpose:
//   Takes a (pc, inst) pair from fetch over a valid/ready handshake and decodes
//   it into register indices, a sign-extended immediate, an instruction-class
//   code and an illegal flag. The result is held in a registered output slot
//   (OUT). A one-entry skid buffer (SKID) absorbs the one instruction that can
//   arrive while OUT is stalled, which lets in_ready be a plain register with
//   no combinational path from out_ready. A flush input drops everything held
//   when execute redirects the PC.
//
// Parameters:
//   ADDR_WIDTH      PC width
//   DATA_WIDTH      instruction / immediate width
//   REG_ADDR_WIDTH  register index width (5 = RV32I, 4 = RV32E)
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   fetch-side handshake (in_ready is registered)
//   in_pc, in_inst        incoming PC and raw instruction word
//   flush                 invalidate OUT and SKID at the next edge
//   out_valid / out_ready execute-side handshake
//   out_pc, out_inst      PC and raw word of the decoded instruction
//   out_rs1/rs2/rd        register fields (always extracted)
//   out_imm               sign-extended immediate
//   out_type              0=R 1=I 2=S 3=B 4=U 5=J 6=SYS 7=ILLEGAL
//   out_illegal           high exactly when out_type == ILLEGAL
//
// Optional build macro:
//   YSYX_23060201_IDU_PERF_EN  adds perf_decoded, perf_stall and perf_flushed
//                              32-bit event counters as extra outputs.
// ============================================================================
module ysyx_23060201_idu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_inst,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [DATA_WIDTH-1:0]     out_inst,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic [2:0]                out_type,
    output logic                      out_illegal
`ifdef YSYX_23060201_IDU_PERF_EN
   ,output logic [31:0]               perf_decoded,
    output logic [31:0]               perf_stall,
    output logic [31:0]               perf_flushed
`endif
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        T_R       = 3'd0,
        T_I       = 3'd1,
        T_S       = 3'd2,
        T_B       = 3'd3,
        T_U       = 3'd4,
        T_J       = 3'd5,
        T_SYS     = 3'd6,
        T_ILLEGAL = 3'd7
    } inst_type_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // nothing held
        S_ONE   = 2'd1,   // OUT full
        S_TWO   = 2'd2    // OUT and SKID full
    } state_e;

    // One decoded instruction, as held in OUT or SKID.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     inst;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     imm;
        inst_type_e                typ;
    } entry_t;

    // ------------------------------------------------------------------------
    // Decode of the entering instruction
    // ------------------------------------------------------------------------
    logic [6:0] opcode;
    inst_type_e dec_typ;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic uses_rd, uses_rs1, uses_rs2;
    logic e_bad_reg;
    entry_t dec_entry;

    assign opcode = in_inst[6:0];

    // NOTE: every signal assigned in an always_comb gets a default first so
    // that no path leaves it unassigned -- that is what keeps latches out.
    always_comb begin
        dec_typ  = T_ILLEGAL;
        dec_imm  = '0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (opcode)
            7'b0110011: begin
                dec_typ  = T_R;
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_typ  = T_I;
                dec_imm  = {{(DATA_WIDTH-12){in_inst[31]}}, in_inst[31:20]};
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            7'b0100011: begin
                dec_typ  = T_S;
                dec_imm  = {{(DATA_WIDTH-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b1100011: begin
                dec_typ  = T_B;
                dec_imm  = {{(DATA_WIDTH-13){in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                dec_typ  = T_U;
                dec_imm  = {in_inst[DATA_WIDTH-1:12], 12'b0};
                uses_rd  = 1'b1;
            end
            7'b1101111: begin
                dec_typ  = T_J;
                dec_imm  = {{(DATA_WIDTH-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
                uses_rd  = 1'b1;
            end
            7'b1110011: begin
                dec_typ  = T_SYS;
                dec_imm  = {{(DATA_WIDTH-12){in_inst[31]}}, in_inst[31:20]};
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
            end
            default: begin
                dec_typ  = T_ILLEGAL;
                dec_imm  = '0;
            end
        endcase

        // RV32E has only x0..x15: a used field with its top bit set is illegal.
        e_bad_reg = (REG_ADDR_WIDTH == 4) &&
                    ((uses_rd  && in_inst[11]) ||
                     (uses_rs1 && in_inst[19]) ||
                     (uses_rs2 && in_inst[24]));
        if (e_bad_reg) begin
            dec_typ = T_ILLEGAL;
            dec_imm = '0;
        end
    end

    always_comb begin
        dec_entry      = '0;
        dec_entry.pc   = in_pc;
        dec_entry.inst = in_inst;
        dec_entry.rs1  = in_inst[15 +: REG_ADDR_WIDTH];
        dec_entry.rs2  = in_inst[20 +: REG_ADDR_WIDTH];
        dec_entry.rd   = in_inst[7  +: REG_ADDR_WIDTH];
        dec_entry.imm  = dec_imm;
        dec_entry.typ  = dec_typ;
    end

    // ------------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------------
    state_e state_q, state_d;
    logic   in_ready_q;
    entry_t out_q, out_d;
    entry_t skid_q;
    logic   out_load, skid_load, out_from_skid;
    logic   in_fire, out_fire;

    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        out_load      = 1'b0;
        skid_load     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is dropped along with what is held.
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        out_load = 1'b1;
                        state_d  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        out_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        state_d       = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        out_d = out_from_skid ? skid_q : dec_entry;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            // Registered copy of "not full next cycle": no path from out_ready.
            in_ready_q <= (state_d != S_TWO);
            if (out_load) begin
                out_q <= out_d;
            end
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read after being
    // written, and the FSM state alone says whether it holds anything.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_q <= dec_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_pc      = out_q.pc;
    assign out_inst    = out_q.inst;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = out_q.imm;
    assign out_type    = out_q.typ;
    assign out_illegal = (out_q.typ == T_ILLEGAL);

`ifdef YSYX_23060201_IDU_PERF_EN
    // ------------------------------------------------------------------------
    // Event counters (cleared by rst only; flush leaves them alone)
    // ------------------------------------------------------------------------
    logic [31:0] perf_decoded_q, perf_stall_q, perf_flushed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_stall_q   <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (out_fire) begin
                perf_decoded_q <= perf_decoded_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush && (state_q != S_EMPTY)) begin
                perf_flushed_q <= perf_flushed_q + 32'd1;
            end
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ysyx_23060201_idu.sv
// ============================================================================
// tb_ysyx_23060201_idu -- directed self-checking bench for ysyx_23060201_idu
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, away from the active edge. Expected values are
// hand-derived constants from the instruction encodings.
// ============================================================================
module tb_ysyx_23060201_idu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060201_idu #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_type   (out_type),
        .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    // Decode table: inst, type, imm, rd, rs1, rs2, illegal
    localparam int NDEC = 8;
    logic [31:0] t_inst [NDEC] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h800002B7,
                                   32'h0000006F, 32'h00100073, 32'h00000000, 32'h002081B3};
    logic [2:0]  t_type [NDEC] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [31:0] t_imm  [NDEC] = '{32'h5, 32'h8, 32'hFFFFFFFC, 32'h80000000,
                                   32'h0, 32'h1, 32'h0, 32'h0};
    logic [4:0]  t_rd   [NDEC] = '{5'd1, 5'd8, 5'd29, 5'd5, 5'd0, 5'd0, 5'd0, 5'd3};
    logic [4:0]  t_rs1  [NDEC] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
    logic [4:0]  t_rs2  [NDEC] = '{5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2};
    logic        t_ill  [NDEC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"},   32'(out_valid),   32'd0);
        check({tag, " in_ready"},    32'(in_ready),    32'd1);
        check({tag, " out_pc"},      out_pc,           32'd0);
        check({tag, " out_inst"},    out_inst,         32'd0);
        check({tag, " out_imm"},     out_imm,          32'd0);
        check({tag, " out_type"},    32'(out_type),    32'd0);
        check({tag, " out_rd"},      32'(out_rd),      32'd0);
        check({tag, " out_rs1"},     32'(out_rs1),     32'd0);
        check({tag, " out_rs2"},     32'(out_rs2),     32'd0);
        check({tag, " out_illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;

        // ---------------- decode coverage (first entry is the basic addi) --
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < NDEC; i++) begin
            in_pc   = 32'h80000000 + 32'(4 * i);
            in_inst = t_inst[i];
            tick();
            check($sformatf("dec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("dec%0d out_pc", i), out_pc, 32'h80000000 + 32'(4 * i));
            check($sformatf("dec%0d out_inst", i), out_inst, t_inst[i]);
            check($sformatf("dec%0d type", i), 32'(out_type), 32'(t_type[i]));
            check($sformatf("dec%0d imm", i), out_imm, t_imm[i]);
            check($sformatf("dec%0d rd", i), 32'(out_rd), 32'(t_rd[i]));
            check($sformatf("dec%0d rs1", i), 32'(out_rs1), 32'(t_rs1[i]));
            check($sformatf("dec%0d rs2", i), 32'(out_rs2), 32'(t_rs2[i]));
            check($sformatf("dec%0d illegal", i), 32'(out_illegal), 32'(t_ill[i]));
            check($sformatf("dec%0d in_ready", i), 32'(in_ready), 32'd1);
        end

        // ---------------- simultaneous transfers, 10 cycles ----------------
        for (int i = 0; i < 10; i++) begin
            in_pc   = 32'h90000000 + 32'(4 * i);
            in_inst = addi_x1(12'(i + 16));
            tick();
            check($sformatf("thru%0d out_pc", i), out_pc, 32'h90000000 + 32'(4 * i));
            check($sformatf("thru%0d imm", i), out_imm, 32'(i + 16));
            check($sformatf("thru%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("thru%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("drain1 out_valid", 32'(out_valid), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h00000100;
        in_inst   = addi_x1(12'h011);
        tick();                                   // A accepted -> ONE
        check("bp A out_pc", out_pc, 32'h00000100);
        check("bp A in_ready", 32'(in_ready), 32'd1);
        in_pc   = 32'h00000104;
        in_inst = addi_x1(12'h022);
        tick();                                   // B accepted -> TWO
        check("bp B in_ready", 32'(in_ready), 32'd0);
        check("bp B out_pc stable", out_pc, 32'h00000100);
        check("bp B imm stable", out_imm, 32'h00000011);
        in_pc   = 32'h00000108;
        in_inst = addi_x1(12'h033);
        tick();                                   // C must not be taken
        check("bp C in_ready", 32'(in_ready), 32'd0);
        check("bp C out_pc stable", out_pc, 32'h00000100);
        tick();
        check("bp C2 out_pc stable", out_pc, 32'h00000100);
        check("bp C2 out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();                                   // A leaves, B to OUT
        check("bp drainB out_pc", out_pc, 32'h00000104);
        check("bp drainB imm", out_imm, 32'h00000022);
        check("bp drainB in_ready", 32'(in_ready), 32'd1);
        tick();                                   // B leaves, C enters
        check("bp drainC out_pc", out_pc, 32'h00000108);
        check("bp drainC imm", out_imm, 32'h00000033);
        in_valid = 1'b0;
        tick();
        check("bp empty out_valid", 32'(out_valid), 32'd0);

        // ---------------- flush in TWO ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h00000200;
        in_inst   = addi_x1(12'h044);
        tick();
        in_pc     = 32'h00000204;
        in_inst   = addi_x1(12'h055);
        tick();
        check("fl2 pre in_ready", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_pc   = 32'h00000208;
        in_inst = addi_x1(12'h066);
        tick();
        check("fl2 out_valid", 32'(out_valid), 32'd0);
        check("fl2 in_ready", 32'(in_ready), 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl2 after out_valid", 32'(out_valid), 32'd0);

        // ---------------- flush in ONE drops the same-cycle input ----------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h00000300;
        in_inst   = addi_x1(12'h077);
        tick();
        check("fl1 pre out_valid", 32'(out_valid), 32'd1);
        flush   = 1'b1;
        in_pc   = 32'h00000304;
        in_inst = addi_x1(12'h088);
        tick();
        check("fl1 out_valid", 32'(out_valid), 32'd0);
        check("fl1 in_ready", 32'(in_ready), 32'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl1 after out_valid", 32'(out_valid), 32'd0);

        // ---------------- reset mid-stream in TWO ----------------
        in_valid = 1'b1;
        in_pc    = 32'h00000400;
        in_inst  = 32'h0020A423;
        tick();
        in_pc    = 32'h00000404;
        in_inst  = 32'hFE000EE3;
        tick();
        check("rst pre in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        check_zero_outputs("rst mid");
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst after out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
